key_detect_module: RTL

- Input-side counterpart to the LED drivers: debounces one active-low pushbutton (Key_In, 0 = pressed) on the 50 MHz system clock.
- Emits single-cycle press and release pulses plus a debounced level.
- Sits between the board pin and the control logic that sequences the LED flash/parallel modules.

---
 rtl/key_defines.sv | 16 +
 rtl/key_sync_module.sv | 25 ++
 rtl/key_detect_module.sv | 131 +++++++++++++
 3 files changed

// File: rtl/key_defines.sv
// Shared constants for the key debouncer: FSM encodings and default timing.
// Default timing assumes the 50 MHz board clock.
package key_defines;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } key_state_t;

   localparam int                   CNT_W_DEF = 26;
   localparam logic [CNT_W_DEF-1:0] T10MS_DEF = 26'd499_999;    // 10 ms - 1
   localparam logic [CNT_W_DEF-1:0] TLONG_DEF = 26'd49_999_999; // 1 s - 1

endpackage

// File: rtl/key_sync_module.sv
// Two-flop synchronizer for an asynchronous board input.
// Both stages reset to 1 so an idle active-low pin reads as released.
module key_sync_module (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/key_detect_module.sv
// Active-low pushbutton debouncer with registered press/release pulses and level.
// Define KEY_LONGPRESS_EN to add a one-shot long-press pulse on Key_Long.
module key_detect_module
   import key_defines::*;
#(
   parameter int               CNT_W = CNT_W_DEF,
   parameter logic [CNT_W-1:0] T10MS = T10MS_DEF,
   parameter logic [CNT_W-1:0] TLONG = TLONG_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic Key_In,
   output logic Key_Press,
   output logic Key_Release,
   output logic Key_State,
   output logic Key_Long
);

   logic             w_sync;
   key_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_press, w_press_nxt;
   logic             r_release, w_release_nxt;
   logic             r_key_state, w_key_state_nxt;

   key_sync_module u_sync (
      .i_clk (CLK),
      .i_rst (RST),
      .i_d   (Key_In),
      .o_q   (w_sync)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_press     <= 1'b0;
         r_release   <= 1'b0;
         r_key_state <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_press     <= w_press_nxt;
         r_release   <= w_release_nxt;
         r_key_state <= w_key_state_nxt;
      end
   end

   // Counter is zeroed in the stable states, so each debounce window starts at 0
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_press_nxt     = 1'b0;
      w_release_nxt   = 1'b0;
      w_key_state_nxt = r_key_state;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (!w_sync) w_state_nxt = DB_PRESS;
         end
         DB_PRESS: begin
            if (w_sync) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == T10MS) begin
               w_state_nxt     = HELD;
               w_press_nxt     = 1'b1;
               w_key_state_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         HELD: begin
            w_cnt_nxt = '0;
            if (w_sync) w_state_nxt = DB_RELEASE;
         end
         DB_RELEASE: begin
            if (!w_sync) begin
               w_state_nxt = HELD;
            end else if (r_cnt == T10MS) begin
               w_state_nxt     = IDLE;
               w_release_nxt   = 1'b1;
               w_key_state_nxt = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign Key_Press   = r_press;
   assign Key_Release = r_release;
   assign Key_State   = r_key_state;

`ifdef KEY_LONGPRESS_EN
   logic [CNT_W-1:0] r_long_cnt;
   logic             r_long_done;
   logic             r_long;

   // Counts through release bounces; r_long_done limits it to one pulse per press
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_long_cnt  <= '0;
         r_long_done <= 1'b0;
         r_long      <= 1'b0;
      end else begin
         r_long <= 1'b0;
         if (r_state == IDLE) begin
            r_long_cnt  <= '0;
            r_long_done <= 1'b0;
         end else if (r_state == HELD || r_state == DB_RELEASE) begin
            if (r_long_cnt == TLONG) begin
               if (!r_long_done) begin
                  r_long      <= 1'b1;
                  r_long_done <= 1'b1;
               end
            end else begin
               r_long_cnt <= r_long_cnt + 1'b1;
            end
         end
      end
   end

   assign Key_Long = r_long;
`else
   logic w_unused_tlong;
   assign w_unused_tlong = ^TLONG;
   assign Key_Long       = 1'b0;
`endif

endmodule
